mem_gateway_client: RTL
=======================

Name: mem_gateway_client

Overview:
- Packet-side initiator for mem_gateway; drives the gateway's receive byte stream and drains its transmit byte stream.
- Collects queued local-bus commands into one request packet: an 8-byte serial header followed by 8 bytes per transaction.
- Streams the request into the gateway, then reads the reply and returns read data with per-packet status.
- Used as on-chip test master and in simulation benches in place of a UDP client.

Parameters:
- jumbo_dw, 14, width of packet length fields.
- fifo_aw, 3, log2 of command FIFO depth (max transactions per packet = 2^fifo_aw).
- rx_gap, 3, idle cycles between length low byte and first payload byte.
- tx_timeout, 1023, cycles allowed from end of request to gw_tx_req before error.

Ports:
- clk  in  1  single clock (gateway clock).
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  push one command into the FIFO.
- cmd_ready  out  1  FIFO not full and state IDLE.
- cmd_rd  in  1  1=read, 0=write.
- cmd_addr  in  24  local-bus address.
- cmd_data  in  32  write data; ignored for reads, sent as given.
- go  in  1  one-cycle pulse; launch a packet with all queued commands.
- busy  out  1  high from go acceptance until done.
- rd_valid  out  1  one-cycle strobe per read result.
- rd_addr  out  24  address echoed for this result.
- rd_data  out  32  data returned by the gateway.
- done  out  1  one-cycle pulse at packet completion.
- err  out  1  status of the last packet, held until the next go.
- gw_rx_ready  out  1  to gateway rx_ready.
- gw_rx_strobe  out  1  to gateway rx_strobe.
- gw_rx_crc  out  1  to gateway rx_crc; driven 0.
- gw_packet_in  out  8  to gateway packet_in.
- gw_tx_req  in  1  from gateway tx_req.
- gw_tx_len  in  jumbo_dw  from gateway tx_len.
- gw_tx_ack  out  1  to gateway tx_ack.
- gw_tx_strobe  out  1  to gateway tx_strobe.
- gw_packet_out  in  8  from gateway packet_out.

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1 once out of reset; FIFO empty; serial=0; state IDLE.
- Command byte layout, MSB first:
  - byte0 = {3'b0, rd, 4'b0};
  - bytes1-3 = addr[23:16], addr[15:8], addr[7:0];
  - bytes4-7 = data[31:24] .. data[7:0].
- Header bytes: 32-bit serial repeated twice (8 bytes), MSB first.
- Packet length: len = 8 + 8*N, where N is the FIFO count captured at go.
- go with empty FIFO: no packet is sent; done pulses next cycle with err=0; serial unchanged.
- go while busy is ignored. cmd_valid while not cmd_ready is dropped.
- State IDLE -> LEN_HI on go with N>0. Serial increments at go.
- LEN_HI, one cycle: gw_rx_ready=1, gw_packet_in={0, len[jumbo_dw-1:8]}.
- LEN_LO, one cycle: gw_packet_in=len[7:0], strobe 0.
- GAP: rx_gap cycles, strobe 0.
- SEND: exactly len consecutive cycles with gw_rx_strobe=1. Header bytes come first, then commands popped in FIFO order. gw_packet_in is registered with the strobe.
- WAIT_TX: wait for gw_tx_req.
  - On gw_tx_req, pulse gw_tx_ack for one cycle, latch gw_tx_len, go to RECV.
  - If the timeout counter reaches tx_timeout: err=1, done, IDLE.
- RECV: gw_tx_strobe=1 for exactly latched-length consecutive cycles. Each gw_packet_out byte is sampled one cycle after its strobe.
  - Header bytes are compared to the sent serial; a mismatch sets err.
  - For each 8-byte transaction, the reply's byte0 rd bit and address bytes are parsed.
  - If rd=1, rd_valid pulses on the cycle after the 8th byte with rd_addr/rd_data. Write replies produce no rd_valid.
  - A latched length different from len sets err; the state machine still receives the full gateway length.
- DONE: one cycle; done=1, busy drops, return to IDLE, cmd_ready rises.
- FIFO full: cmd_ready=0 at count 2^fifo_aw; a 2^fifo_aw-transaction packet is legal.
- rst_n asserted mid-packet: immediate return to reset state. FIFO is flushed and no done is issued.

Test Plan:
- Queue write 0x000000/0xdeadbeef, read 0x100000, read 0x200000, write 0x300000/0x01020304; go against mem_gateway with a mux returning "Hell", "o wo", "rld!"
  -> len=40 sent as 0x00,0x28 with a 3-cycle gap.
  -> rd_valid twice: 0x100000/0x6f20776f, then 0x200000/0x726c6421.
  -> done, err=0.
- go with empty FIFO -> done one cycle later, err=0, gw_rx_ready never asserted.
- Fill 8 commands; 9th cmd_valid -> cmd_ready=0 and command dropped; packet len=72 (0x00,0x48).
- Bench holds gw_tx_req low -> err=1 and done exactly tx_timeout cycles after SEND ends.
- Bench gateway model corrupts a serial byte -> err=1, read data still reported.
- Assert rst_n low during SEND -> all gw_* outputs 0 immediately; next go with new commands produces a correct packet with serial=1.

Source files
------------

// File: rtl/mem_gateway_client.sv
// rtl/mem_gateway_client.sv - packet-side initiator that batches local-bus commands into mem_gateway request packets
module mem_gateway_client #(
   parameter int jumbo_dw   = 14,
   parameter int fifo_aw    = 3,
   parameter int rx_gap     = 3,
   parameter int tx_timeout = 1023
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_rd_i,
   input  logic [23:0]         cmd_addr_i,
   input  logic [31:0]         cmd_data_i,
   input  logic                go_i,
   output logic                busy_o,
   output logic                rd_valid_o,
   output logic [23:0]         rd_addr_o,
   output logic [31:0]         rd_data_o,
   output logic                done_o,
   output logic                err_o,
   output logic                gw_rx_ready_o,
   output logic                gw_rx_strobe_o,
   output logic                gw_rx_crc_o,
   output logic [7:0]          gw_packet_in_o,
   input  logic                gw_tx_req_i,
   input  logic [jumbo_dw-1:0] gw_tx_len_i,
   output logic                gw_tx_ack_o,
   output logic                gw_tx_strobe_o,
   input  logic [7:0]          gw_packet_out_i
);

   localparam int DEPTH = 1 << fifo_aw;
   // One counter serves the gap, byte positions and the reply timeout; 16 bits
   // covers any jumbo length up to 16 bits and the default timeout.
   localparam int CW = 16;
   localparam logic [fifo_aw:0] CNT_FULL = {1'b1, {fifo_aw{1'b0}}};

   typedef enum logic [3:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_GAP, S_SEND, S_WAIT_TX, S_RECV, S_DRAIN, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [31:0]          serial_q, serial_d;
   logic [jumbo_dw-1:0]  len_q, len_d;
   logic [jumbo_dw-1:0]  tx_len_q, tx_len_d;
   logic                 err_q, err_d;

   // Command FIFO entry: {rd, addr[23:0], data[31:0]}
   logic [56:0]          mem_q [DEPTH];
   logic [fifo_aw-1:0]   wr_ptr_q, rd_ptr_q;
   logic [fifo_aw:0]     count_q;
   logic                 push, pop;

   // Reply side: byte arrives one cycle after its strobe
   logic                 rx_vld_q;
   logic [CW-1:0]        rx_idx_q;
   logic                 rsp_rd_q;
   logic [23:0]          rsp_addr_q;
   logic [31:0]          rsp_data_q;
   logic                 rd_valid_q;

   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
      return 8'(w >> {~i, 3'b000});
   endfunction

   function automatic logic [7:0] cmd_byte(input logic [56:0] e, input logic [2:0] i);
      logic [7:0] b;
      case (i)
         3'd0:                b = {3'b000, e[56], 4'b0000};
         3'd1, 3'd2, 3'd3:    b = 8'(e[55:32] >> {~i[1:0], 3'b000});
         default:             b = word_byte(e[31:0], i[1:0]);
      endcase
      return b;
   endfunction

   assign cmd_ready_o = (state_q == S_IDLE) && (count_q != CNT_FULL);
   assign push        = cmd_valid_i && cmd_ready_o;
   assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o      = (state_q == S_DONE);
   assign err_o       = err_q;
   assign gw_rx_crc_o = 1'b0;
   assign rd_valid_o  = rd_valid_q;
   assign rd_addr_o   = rsp_addr_q;
   assign rd_data_o   = rsp_data_q;

   // Control registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         serial_q <= '0;
         len_q    <= '0;
         tx_len_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         serial_q <= serial_d;
         len_q    <= len_d;
         tx_len_q <= tx_len_d;
         err_q    <= err_d;
      end
   end

   // Packet sequencer: next state and gateway-facing strobes
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      serial_d       = serial_q;
      len_d          = len_q;
      tx_len_d       = tx_len_q;
      err_d          = err_q;
      gw_rx_ready_o  = 1'b0;
      gw_rx_strobe_o = 1'b0;
      gw_packet_in_o = 8'h00;
      gw_tx_ack_o    = 1'b0;
      gw_tx_strobe_o = 1'b0;
      pop            = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go_i) begin
               err_d = 1'b0;
               cnt_d = '0;
               if (count_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  serial_d = serial_q + 32'd1;
                  len_d    = jumbo_dw'({count_q, 3'b000}) + jumbo_dw'(8);
                  state_d  = S_LEN_HI;
               end
            end
         end
         S_LEN_HI: begin
            gw_rx_ready_o  = 1'b1;
            gw_packet_in_o = 8'(len_q >> 8);
            state_d        = S_LEN_LO;
         end
         S_LEN_LO: begin
            gw_packet_in_o = len_q[7:0];
            cnt_d          = '0;
            state_d        = (rx_gap == 0) ? S_SEND : S_GAP;
         end
         S_GAP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) >= CW'(rx_gap)) begin
               cnt_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            gw_rx_strobe_o = 1'b1;
            if (cnt_q < CW'(8)) begin
               gw_packet_in_o = word_byte(serial_q, cnt_q[1:0]);
            end else begin
               gw_packet_in_o = cmd_byte(mem_q[rd_ptr_q], cnt_q[2:0]);
               pop            = (cnt_q[2:0] == 3'd7);
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CW'(len_q)) begin
               // count starts at 1 so DONE lands tx_timeout cycles after the last strobe
               cnt_d   = CW'(1);
               state_d = S_WAIT_TX;
            end
         end
         S_WAIT_TX: begin
            if (gw_tx_req_i) begin
               gw_tx_ack_o = 1'b1;
               tx_len_d    = gw_tx_len_i;
               cnt_d       = '0;
               if (gw_tx_len_i != len_q) err_d = 1'b1;
               state_d = (gw_tx_len_i == '0) ? S_DONE : S_RECV;
            end else if (cnt_q >= CW'(tx_timeout - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RECV: begin
            gw_tx_strobe_o = 1'b1;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == CW'(tx_len_q)) state_d = S_DRAIN;
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Reply header must echo the serial we sent
      if (rx_vld_q && (rx_idx_q < CW'(8)) &&
          (gw_packet_out_i != word_byte(serial_q, rx_idx_q[1:0]))) begin
         err_d = 1'b1;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + fifo_aw'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + fifo_aw'(1);
         if (push && !pop)      count_q <= count_q + (fifo_aw + 1)'(1);
         else if (pop && !push) count_q <= count_q - (fifo_aw + 1)'(1);
      end
   end

   // FIFO storage
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_rd_i, cmd_addr_i, cmd_data_i};
   end

   // Reply parser: assemble each 8-byte transaction and strobe read results
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_vld_q   <= 1'b0;
         rx_idx_q   <= '0;
         rsp_rd_q   <= 1'b0;
         rsp_addr_q <= '0;
         rsp_data_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rx_vld_q   <= gw_tx_strobe_o;
         rx_idx_q   <= cnt_q;
         rd_valid_q <= 1'b0;
         if (rx_vld_q && (rx_idx_q >= CW'(8))) begin
            case (rx_idx_q[2:0])
               3'd0: rsp_rd_q          <= gw_packet_out_i[4];
               3'd1: rsp_addr_q[23:16] <= gw_packet_out_i;
               3'd2: rsp_addr_q[15:8]  <= gw_packet_out_i;
               3'd3: rsp_addr_q[7:0]   <= gw_packet_out_i;
               3'd4: rsp_data_q[31:24] <= gw_packet_out_i;
               3'd5: rsp_data_q[23:16] <= gw_packet_out_i;
               3'd6: rsp_data_q[15:8]  <= gw_packet_out_i;
               default: begin
                  rsp_data_q[7:0] <= gw_packet_out_i;
                  rd_valid_q      <= rsp_rd_q;
               end
            endcase
         end
      end
   end

endmodule
